kairo_decode_stage: RTL and testbench

//  Registered RV32IM/Zicsr decode stage between fetch and execute. Accepts {PC, instruction} over valid/ready.

---
 rtl/kairo_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_kairo_decode_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kairo_decode_stage.sv
// RV32IM/Zicsr decode stage: combinational decode of the fetch bundle captured into a
// two-entry (main + skid) buffer so the output bundle and IN_READY are both registered.
module kairo_decode_stage #(
    parameter int PC_WIDTH     = 32,
    parameter int ENABLE_M     = 1,
    parameter int ENABLE_ZICSR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [31:0]         in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [3:0]          out_class,
    output logic [3:0]          out_func,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [31:0]         out_imm,
    output logic [11:0]         out_csr,
    output logic                out_ill
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] CLS_ALU     = 4'd0;
    localparam logic [3:0] CLS_ALUI    = 4'd1;
    localparam logic [3:0] CLS_LUI     = 4'd2;
    localparam logic [3:0] CLS_AUIPC   = 4'd3;
    localparam logic [3:0] CLS_JAL     = 4'd4;
    localparam logic [3:0] CLS_JALR    = 4'd5;
    localparam logic [3:0] CLS_BRANCH  = 4'd6;
    localparam logic [3:0] CLS_LOAD    = 4'd7;
    localparam logic [3:0] CLS_STORE   = 4'd8;
    localparam logic [3:0] CLS_MULDIV  = 4'd9;
    localparam logic [3:0] CLS_FENCE   = 4'd10;
    localparam logic [3:0] CLS_SYSTEM  = 4'd11;
    localparam logic [3:0] CLS_CSR     = 4'd12;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [3:0]          cls;
        logic [3:0]          func;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [11:0]         csr;
        logic                ill;
    } bundle_t;

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  f3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic        legal_s;
    bundle_t     dec_s;

    bundle_t main_r;
    bundle_t skid_r;
    logic    main_valid_r;
    logic    skid_valid_r;
    logic    in_ready_r;
    bundle_t main_n_s;
    bundle_t skid_n_s;
    logic    main_valid_n_s;
    logic    skid_valid_n_s;
    logic    in_fire_s;
    logic    out_fire_s;

    assign opcode_s = in_inst[6:0];
    assign rd_s     = in_inst[11:7];
    assign f3_s     = in_inst[14:12];
    assign rs1_s    = in_inst[19:15];
    assign rs2_s    = in_inst[24:20];
    assign f7_s     = in_inst[31:25];
    assign imm_i_s  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b_s  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u_s  = {in_inst[31:12], 12'h000};
    assign imm_j_s  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Instruction decode and legality; illegal encodings collapse to a zeroed ILLEGAL bundle.
    always_comb begin
        dec_s    = '0;
        dec_s.pc = in_pc;
        legal_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                dec_s.rd  = rd_s;
                dec_s.rs1 = rs1_s;
                dec_s.rs2 = rs2_s;
                if (f7_s == 7'b0000000) begin
                    legal_s    = 1'b1;
                    dec_s.cls  = CLS_ALU;
                    dec_s.func = {1'b0, f3_s};
                end else if (f7_s == 7'b0100000 && (f3_s == 3'b000 || f3_s == 3'b101)) begin
                    legal_s    = 1'b1;
                    dec_s.cls  = CLS_ALU;
                    dec_s.func = {1'b1, f3_s};
                end else if (f7_s == 7'b0000001 && ENABLE_M != 0) begin
                    legal_s    = 1'b1;
                    dec_s.cls  = CLS_MULDIV;
                    dec_s.func = {1'b0, f3_s};
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OPIMM: begin
                dec_s.cls = CLS_ALUI;
                dec_s.rd  = rd_s;
                dec_s.rs1 = rs1_s;
                dec_s.imm = imm_i_s;
                if (f3_s == 3'b001) begin
                    legal_s    = (f7_s == 7'b0000000);
                    dec_s.func = {1'b0, f3_s};
                end else if (f3_s == 3'b101) begin
                    legal_s    = (f7_s == 7'b0000000) || (f7_s == 7'b0100000);
                    dec_s.func = {f7_s[5], f3_s};
                end else begin
                    legal_s    = 1'b1;
                    dec_s.func = {1'b0, f3_s};
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                legal_s   = 1'b1;
                dec_s.cls = (opcode_s == OPC_LUI) ? CLS_LUI : CLS_AUIPC;
                dec_s.rd  = rd_s;
                dec_s.imm = imm_u_s;
            end
            OPC_JAL: begin
                legal_s   = 1'b1;
                dec_s.cls = CLS_JAL;
                dec_s.rd  = rd_s;
                dec_s.imm = imm_j_s;
            end
            OPC_JALR: begin
                legal_s   = (f3_s == 3'b000);
                dec_s.cls = CLS_JALR;
                dec_s.rd  = rd_s;
                dec_s.rs1 = rs1_s;
                dec_s.imm = imm_i_s;
            end
            OPC_BRANCH: begin
                legal_s    = (f3_s != 3'b010) && (f3_s != 3'b011);
                dec_s.cls  = CLS_BRANCH;
                dec_s.func = {1'b0, f3_s};
                dec_s.rs1  = rs1_s;
                dec_s.rs2  = rs2_s;
                dec_s.imm  = imm_b_s;
            end
            OPC_LOAD: begin
                legal_s    = (f3_s != 3'b011) && (f3_s != 3'b110) && (f3_s != 3'b111);
                dec_s.cls  = CLS_LOAD;
                dec_s.func = {1'b0, f3_s};
                dec_s.rd   = rd_s;
                dec_s.rs1  = rs1_s;
                dec_s.imm  = imm_i_s;
            end
            OPC_STORE: begin
                legal_s    = (f3_s == 3'b000) || (f3_s == 3'b001) || (f3_s == 3'b010);
                dec_s.cls  = CLS_STORE;
                dec_s.func = {1'b0, f3_s};
                dec_s.rs1  = rs1_s;
                dec_s.rs2  = rs2_s;
                dec_s.imm  = imm_s_s;
            end
            OPC_FENCE: begin
                legal_s    = (f3_s == 3'b000) || (f3_s == 3'b001);
                dec_s.cls  = CLS_FENCE;
                dec_s.func = {1'b0, f3_s};
            end
            OPC_SYSTEM: begin
                if (f3_s == 3'b000) begin
                    dec_s.cls = CLS_SYSTEM;
                    if (rs1_s != 5'd0 || rd_s != 5'd0) begin
                        legal_s = 1'b0;
                    end else if (in_inst[31:20] == 12'h000) begin
                        legal_s    = 1'b1;
                        dec_s.func = 4'd0;
                    end else if (in_inst[31:20] == 12'h001) begin
                        legal_s    = 1'b1;
                        dec_s.func = 4'd1;
                    end else if (in_inst[31:20] == 12'h302) begin
                        legal_s    = 1'b1;
                        dec_s.func = 4'd2;
                    end else begin
                        legal_s = 1'b0;
                    end
                end else if (f3_s == 3'b100) begin
                    legal_s = 1'b0;
                end else begin
                    // CSR*I forms carry a 5-bit zero-extended immediate in the rs1 field
                    legal_s    = (ENABLE_ZICSR != 0);
                    dec_s.cls  = CLS_CSR;
                    dec_s.func = {1'b0, f3_s};
                    dec_s.rd   = rd_s;
                    dec_s.csr  = in_inst[31:20];
                    if (f3_s[2]) begin
                        dec_s.imm = {27'd0, rs1_s};
                    end else begin
                        dec_s.rs1 = rs1_s;
                    end
                end
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        if (!legal_s) begin
            dec_s     = '0;
            dec_s.pc  = in_pc;
            dec_s.cls = CLS_ILLEGAL;
            dec_s.ill = 1'b1;
        end else begin
            dec_s.ill = 1'b0;
        end
    end

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_valid_r & out_ready;

    // Next state of the main/skid buffer pair.
    always_comb begin
        main_n_s       = main_r;
        skid_n_s       = skid_r;
        main_valid_n_s = main_valid_r;
        skid_valid_n_s = skid_valid_r;
        if (flush) begin
            main_valid_n_s = 1'b0;
            skid_valid_n_s = 1'b0;
        end else if (!main_valid_r || out_fire_s) begin
            if (skid_valid_r) begin
                main_n_s       = skid_r;
                main_valid_n_s = 1'b1;
                skid_valid_n_s = 1'b0;
            end else if (in_fire_s) begin
                main_n_s       = dec_s;
                main_valid_n_s = 1'b1;
            end else begin
                main_valid_n_s = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                skid_n_s       = dec_s;
                skid_valid_n_s = 1'b1;
            end else begin
                skid_valid_n_s = skid_valid_r;
            end
        end
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            main_r       <= main_n_s;
            skid_r       <= skid_n_s;
            main_valid_r <= main_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= !skid_valid_n_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_pc    = main_r.pc;
    assign out_class = main_r.cls;
    assign out_func  = main_r.func;
    assign out_rd    = main_r.rd;
    assign out_rs1   = main_r.rs1;
    assign out_rs2   = main_r.rs2;
    assign out_imm   = main_r.imm;
    assign out_csr   = main_r.csr;
    assign out_ill   = main_r.ill;

endmodule

// File: tb/tb_kairo_decode_stage.sv
// Scoreboard bench for kairo_decode_stage: two instances (ENABLE_M=1 and ENABLE_M=0) share
// stimulus; expected bundles are queued on acceptance and popped by per-instance monitors.
module tb_kairo_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [11:0] csr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_ready;

    logic        in_ready, out_valid, out_ill;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_class, out_func;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [11:0] out_csr;

    logic        in_ready0, out_valid0, out_ill0;
    logic [31:0] out_pc0, out_imm0;
    logic [3:0]  out_class0, out_func0;
    logic [4:0]  out_rd0, out_rs10, out_rs20;
    logic [11:0] out_csr0;

    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t mon_e1, mon_a1, mon_e0, mon_a0;

    kairo_decode_stage #(.PC_WIDTH(32), .ENABLE_M(1), .ENABLE_ZICSR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_class(out_class), .out_func(out_func), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_csr(out_csr), .out_ill(out_ill)
    );

    kairo_decode_stage #(.PC_WIDTH(32), .ENABLE_M(0), .ENABLE_ZICSR(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid0), .out_ready(out_ready),
        .out_pc(out_pc0), .out_class(out_class0), .out_func(out_func0), .out_rd(out_rd0),
        .out_rs1(out_rs10), .out_rs2(out_rs20), .out_imm(out_imm0), .out_csr(out_csr0), .out_ill(out_ill0)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] cls, input logic [3:0] func,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [11:0] csr);
        exp_t e;
        e.pc = pc; e.cls = cls; e.func = func; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.csr = csr; e.ill = (cls == 4'd15);
        return e;
    endfunction

    function automatic exp_t ill(input logic [31:0] pc);
        return mk(pc, 4'd15, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic cmp(input string tag, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s bundle: got pc=%h cls=%0d func=%0d rd=%0d rs1=%0d rs2=%0d imm=%h csr=%h ill=%b required pc=%h cls=%0d func=%0d rd=%0d rs1=%0d rs2=%0d imm=%h csr=%h ill=%b",
                     tag, a.pc, a.cls, a.func, a.rd, a.rs1, a.rs2, a.imm, a.csr, a.ill,
                     e.pc, e.cls, e.func, e.rd, e.rs1, e.rs2, e.imm, e.csr, e.ill);
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input exp_t e1, input exp_t e0,
                        input bit keep);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pc=%h: in_ready got %b required 1", pc, in_ready);
        end else begin
            if (keep) begin
                q1.push_back(e1);
                q0.push_back(e0);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Monitor for the ENABLE_M=1 instance.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            mon_a1 = '{out_pc, out_class, out_func, out_rd, out_rs1, out_rs2, out_imm, out_csr, out_ill};
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m1_unexpected: got pc=%h required no output", out_pc);
            end else begin
                mon_e1 = q1.pop_front();
                cmp("m1", mon_a1, mon_e1);
            end
        end
    end

    // Monitor for the ENABLE_M=0 instance.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid0 && out_ready) begin
            mon_a0 = '{out_pc0, out_class0, out_func0, out_rd0, out_rs10, out_rs20, out_imm0, out_csr0, out_ill0};
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m0_unexpected: got pc=%h required no output", out_pc0);
            end else begin
                mon_e0 = q0.pop_front();
                cmp("m0", mon_a0, mon_e0);
            end
        end
    end

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_MUL  = 32'h027302B3;

    initial begin
        exp_t e_addi, e_sub;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_inst   = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_in_ready0", {31'd0, in_ready0}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming with 1-cycle latency
        out_ready = 1'b1;
        e_addi = mk(32'h100, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0);
        send(32'h100, I_ADDI, e_addi, e_addi, 1'b1);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_pc", out_pc, 32'h100);
        e_sub = mk(32'h104, 4'd0, 4'd8, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0);
        send(32'h104, I_SUB, e_sub, e_sub, 1'b1);
        send(32'h108, I_MUL, mk(32'h108, 4'd9, 4'd0, 5'd5, 5'd6, 5'd7, 32'd0, 12'd0), ill(32'h108), 1'b1);
        send(32'h10C, 32'hFE000EE3, mk(32'h10C, 4'd6, 4'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 12'd0),
             mk(32'h10C, 4'd6, 4'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 12'd0), 1'b1);
        send(32'h110, 32'h001000EF, mk(32'h110, 4'd4, 4'd0, 5'd1, 5'd0, 5'd0, 32'h800, 12'd0),
             mk(32'h110, 4'd4, 4'd0, 5'd1, 5'd0, 5'd0, 32'h800, 12'd0), 1'b1);
        send(32'h114, 32'h300FD073, mk(32'h114, 4'd12, 4'd5, 5'd0, 5'd0, 5'd0, 32'd31, 12'h300),
             mk(32'h114, 4'd12, 4'd5, 5'd0, 5'd0, 5'd0, 32'd31, 12'h300), 1'b1);
        send(32'h118, 32'h0081A103, mk(32'h118, 4'd7, 4'd2, 5'd2, 5'd3, 5'd0, 32'd8, 12'd0),
             mk(32'h118, 4'd7, 4'd2, 5'd2, 5'd3, 5'd0, 32'd8, 12'd0), 1'b1);
        send(32'h11C, 32'h4032D213, mk(32'h11C, 4'd1, 4'd13, 5'd4, 5'd5, 5'd0, 32'h403, 12'd0),
             mk(32'h11C, 4'd1, 4'd13, 5'd4, 5'd5, 5'd0, 32'h403, 12'd0), 1'b1);
        send(32'h120, 32'h30200073, mk(32'h120, 4'd11, 4'd2, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0),
             mk(32'h120, 4'd11, 4'd2, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0), 1'b1);
        send(32'h124, 32'h00000000, ill(32'h124), ill(32'h124), 1'b1);
        send(32'h128, 32'hFFFFFFFF, ill(32'h128), ill(32'h128), 1'b1);
        send(32'h12C, 32'h02109093, ill(32'h12C), ill(32'h12C), 1'b1);
        send(32'h130, 32'h000000F3, ill(32'h130), ill(32'h130), 1'b1);
        repeat (3) @(negedge clk);

        // Back-pressure: two accepts fill main+skid, third waits
        out_ready = 1'b0;
        send(32'h200, I_ADDI, mk(32'h200, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0),
             mk(32'h200, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0), 1'b1);
        send(32'h204, I_SUB, mk(32'h204, 4'd0, 4'd8, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0),
             mk(32'h204, 4'd0, 4'd8, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0), 1'b1);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        fork
            send(32'h208, I_MUL, mk(32'h208, 4'd9, 4'd0, 5'd5, 5'd6, 5'd7, 32'd0, 12'd0), ill(32'h208), 1'b1);
            begin
                repeat (3) @(negedge clk);
                chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_pc", out_pc, 32'h200);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // Flush with both entries full and a same-cycle input
        out_ready = 1'b0;
        send(32'h300, I_ADDI, e_addi, e_addi, 1'b0);
        send(32'h304, I_SUB, e_sub, e_sub, 1'b0);
        in_valid = 1'b1;
        in_pc    = 32'h308;
        in_inst  = I_ADDI;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_valid0", {31'd0, out_valid0}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        send(32'h30C, I_ADDI, mk(32'h30C, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0),
             mk(32'h30C, 4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0), 1'b1);

        for (int i = 0; i < 50 && (q1.size() != 0 || q0.size() != 0); i++) begin
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q0_drained", q0.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
